wb_burst_reader: RTL
====================

# wb_burst_reader

Wishbone B3 master that streams a block of words from a Wishbone slave, typically the boot ROM or RAM, into a first-word-fall-through output FIFO. A command gives a start byte address and a word count. The block splits it into incrementing bursts (registered-feedback CTI/BTE), or into classic cycles, and never starts a burst the FIFO cannot absorb. It sits between the ROM/RAM slave port and consumers such as loaders or DMA sinks.

## Interface

- dw, 32, data width in bits; must be 32 (sel is 4 bits).
- aw, 32, byte address width.
- max_burst, 8, maximum beats per burst, power of 2, ≥2.
- fifo_depth, 16, output FIFO entries, power of 2, ≥ max_burst.

- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- cmd_adr_i  in  aw  start byte address; bits [1:0] are ignored and treated as 0.
- cmd_len_i  in  16  word count, 0..65535.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when valid & ready.
- wbm_adr_o  out  aw  byte address, word aligned.
- wbm_dat_o  out  dw  tied 0.
- wbm_sel_o  out  4  tied 4'hf.
- wbm_we_o  out  1  tied 0.
- wbm_cyc_o, wbm_stb_o  out  1  bus cycle and strobe; always equal.
- wbm_cti_o  out  3  000 classic, 010 incrementing, 111 end of burst.
- wbm_bte_o  out  2  tied 00 (linear).
- wbm_dat_i  in  dw  read data.
- wbm_ack_i, wbm_err_i  in  1  slave termination.
- data_o  out  dw  FIFO head.
- data_valid_o  out  1  FIFO not empty.
- data_ready_i  in  1  pop when valid & ready.
- busy_o  out  1  command in progress.
- done_o  out  1  one-cycle pulse when a command completes normally.
- err_o  out  1  one-cycle pulse when a command is aborted by wbm_err_i.

## Operation

- States: IDLE, WAIT_SPACE, BURST, GAP.
- IDLE:
  - cmd_ready_o=1.
  - On accept, latch the address and remaining count = len.
  - len=0: done_o pulses next cycle; stay in IDLE.
  - Otherwise go to WAIT_SPACE.
- WAIT_SPACE:
  - n = min(remaining, max_burst).
  - When FIFO free entries ≥ n, go to BURST and assert cyc/stb.
  - The beat counter is n, with width $clog2(max_burst)+1.
- BURST:
  - cti=010 on all beats except the last; cti=111 on the last beat.
  - n=1 uses cti=000.
  - On each ack: write wbm_dat_i to the FIFO, add 4 to the address (wraps modulo 2^aw), decrement remaining and the beat counter.
  - On the last ack: drop cyc/stb. If remaining=0, pulse done_o and go to IDLE; otherwise go to GAP.
- GAP: exactly one cycle with cyc=0, then WAIT_SPACE.
- Error: wbm_err_i while stb=1 does not write the FIFO.
  - cyc drops the next cycle, err_o pulses, remaining is cleared, state goes to IDLE.
  - FIFO contents already written are kept.
- ack and err in the same cycle: err wins.
- FIFO: push and pop in the same cycle leave the count unchanged. Space reservation guarantees no push when full.
- busy_o=1 in every state except IDLE.

## Timing

- Reset values: cyc/stb/cti/adr=0, cmd_ready_o=0 during reset and 1 the first cycle after, data_valid_o=0, busy_o=0, done_o=0, err_o=0.
- Reset mid-burst drops cyc the next edge and flushes the FIFO.
- cyc/stb rise one cycle after command acceptance, or after space becomes available.
- All bus outputs are registered.
- Address and cti update in the cycle after the ack that advanced them. stb stays high for the whole burst, with no wait states inserted by the master.
- A pushed word appears on data_o (data_valid_o=1) the cycle after its ack.
- done_o pulses the cycle after the final ack.

## Configuration

- WB_BURST_READER_BURST_EN
  - Defined: bursts as described.
  - Undefined: every beat is a classic cycle (cti=000) and max_burst is treated as 1.
  - cyc/stb stay asserted across consecutive words with the address updated after each ack; GAP is skipped.

## Test plan

- cmd adr=0x100, len=8, data_ready=1, ROM slave: one burst with adr 0x100..0x11C and cti 010×7 then 111. Eight words out in order; done_o pulses once; 9 cycles from stb to the last ack.
- len=20, max_burst=8: bursts of 8, 8, 4, each separated by a one-cycle cyc=0 gap; 20 words out; the final address is 0x14C for start 0x100.
- len=1: single beat with cti=000; one word out; done_o pulses.
- data_ready_i=0, len=32, fifo_depth=16: two bursts of 8 fill the FIFO, then the master waits in WAIT_SPACE with cyc=0. Release ready; all 32 words arrive with no loss and no overflow.
- wbm_err_i on beat 3 of 8: exactly 2 words in the FIFO, err_o pulses, done_o never pulses, cyc=0 the next cycle, cmd_ready_o=1.
- Reset asserted mid-burst, then len=0 command: cyc=0 and data_valid_o=0 after the reset edge; done_o pulses with no bus activity.

Source files
------------

// File: rtl/wb_burst_reader.sv
// Wishbone B3 read master that streams a block of words into a first-word-fall-through FIFO.
// Define WB_BURST_READER_BURST_EN for incrementing bursts; otherwise every beat is a classic cycle.
module wb_burst_reader #(
  parameter int unsigned dw         = 32,
  parameter int unsigned aw         = 32,
  parameter int unsigned max_burst  = 8,
  parameter int unsigned fifo_depth = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [aw-1:0] cmd_adr_i,
  input  logic [15:0]   cmd_len_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  output logic [aw-1:0] wbm_adr_o,
  output logic [dw-1:0] wbm_dat_o,
  output logic [3:0]    wbm_sel_o,
  output logic          wbm_we_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic [2:0]    wbm_cti_o,
  output logic [1:0]    wbm_bte_o,
  input  logic [dw-1:0] wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i,
  output logic [dw-1:0] data_o,
  output logic          data_valid_o,
  input  logic          data_ready_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

`ifdef WB_BURST_READER_BURST_EN
  localparam bit          burst_en = 1'b1;
  localparam int unsigned mb       = max_burst;
`else
  localparam bit          burst_en = 1'b0;
  localparam int unsigned mb       = 1;
`endif
  localparam int unsigned bw = $clog2(max_burst) + 1;
  localparam int unsigned pw = $clog2(fifo_depth);
  localparam int unsigned cw = pw + 1;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {IDLE, WAIT_SPACE, BURST, GAP} state_t;

  state_t        state_q, state_d;
  logic [aw-1:0] adr_q, adr_d;
  logic [15:0]   rem_q, rem_d;
  logic [bw-1:0] beat_q, beat_d, burst_n;
  logic [2:0]    cti_q, cti_d;
  logic          cyc_q, cyc_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          rdy_q, busy_q;

  logic [dw-1:0] mem [fifo_depth];
  logic [pw-1:0] wr_ptr_q, rd_ptr_q;
  logic [cw-1:0] cnt_q, cnt_d, free;
  logic          valid_q;

  logic accept, ack_ok, bus_err, last_beat, space_ok, chain, push, pop;

  assign accept    = cmd_valid_i & rdy_q;
  assign ack_ok    = (state_q == BURST) & wbm_ack_i & ~wbm_err_i;
  assign bus_err   = (state_q == BURST) & wbm_err_i;
  assign last_beat = (beat_q == bw'(1));
  assign free      = cw'(fifo_depth) - cnt_q;
  assign space_ok  = 32'(free) >= 32'(burst_n);
  assign push      = ack_ok;
  assign pop       = valid_q & data_ready_i;

  // Beats of the next burst: the smaller of what is left and the burst limit.
  always_comb begin
    if (32'(rem_q) >= mb) burst_n = bw'(mb);
    else                  burst_n = bw'(rem_q);
  end

  // Classic mode keeps the cycle open while the word after this push still fits.
`ifdef WB_BURST_READER_BURST_EN
  assign chain = 1'b0;
`else
  assign chain = (32'(cnt_q) + 32'd2) <= fifo_depth;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (accept && cmd_len_i != 16'd0) state_d = WAIT_SPACE;
      WAIT_SPACE: if (space_ok) state_d = BURST;
      BURST: begin
        if (bus_err) begin
          state_d = IDLE;
        end else if (ack_ok && last_beat) begin
          if (rem_q == 16'd1) state_d = IDLE;
          else if (chain)     state_d = BURST;
          else if (burst_en)  state_d = GAP;
          else                state_d = WAIT_SPACE;
        end
      end
      GAP:        state_d = WAIT_SPACE;
      default:    state_d = IDLE;
    endcase
  end

  // Next values of the bus outputs and the command bookkeeping.
  always_comb begin
    adr_d  = adr_q;
    rem_d  = rem_q;
    beat_d = beat_q;
    cyc_d  = cyc_q;
    cti_d  = cti_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          adr_d  = cmd_adr_i & ~aw'(3);
          rem_d  = cmd_len_i;
          done_d = (cmd_len_i == 16'd0);
        end
      end
      WAIT_SPACE: begin
        if (space_ok) begin
          cyc_d  = 1'b1;
          beat_d = burst_n;
          cti_d  = (burst_n == bw'(1)) ? CTI_CLASSIC : CTI_INCR;
        end
      end
      BURST: begin
        if (bus_err) begin
          cyc_d = 1'b0;
          cti_d = CTI_CLASSIC;
          rem_d = 16'd0;
          err_d = 1'b1;
        end else if (ack_ok) begin
          adr_d  = adr_q + aw'(4);
          rem_d  = rem_q - 16'd1;
          beat_d = beat_q - bw'(1);
          if (last_beat) begin
            cti_d = CTI_CLASSIC;
            if (rem_q == 16'd1) begin
              done_d = 1'b1;
              cyc_d  = 1'b0;
            end else if (chain) begin
              beat_d = bw'(1);
            end else begin
              cyc_d = 1'b0;
            end
          end else if (beat_q == bw'(2)) begin
            cti_d = CTI_END;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      adr_q  <= '0;
      rem_q  <= '0;
      beat_q <= '0;
      cyc_q  <= 1'b0;
      cti_q  <= CTI_CLASSIC;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      rdy_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      adr_q  <= adr_d;
      rem_q  <= rem_d;
      beat_q <= beat_d;
      cyc_q  <= cyc_d;
      cti_q  <= cti_d;
      done_q <= done_d;
      err_q  <= err_d;
      rdy_q  <= (state_d == IDLE);
      busy_q <= (state_d != IDLE);
    end
  end

  // Output FIFO; space is reserved before each burst so a push never meets a full FIFO.
  assign cnt_d = cnt_q + cw'(push) - cw'(pop);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + pw'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + pw'(1);
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr_q] <= wbm_dat_i;
  end

  assign cmd_ready_o  = rdy_q;
  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = '0;
  assign wbm_sel_o    = 4'hf;
  assign wbm_we_o     = 1'b0;
  assign wbm_cyc_o    = cyc_q;
  assign wbm_stb_o    = cyc_q;
  assign wbm_cti_o    = cti_q;
  assign wbm_bte_o    = 2'b00;
  assign data_o       = mem[rd_ptr_q];
  assign data_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
